// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: ALU-op codes of the memory
// instructions, reset/NOP constants, decoded memory-op and FSM state types.
package mem_access_stage_pkg;

  localparam int         RegWidth   = 32;
  localparam logic       RstEnable  = 1'b1;
  localparam logic [4:0] NOPRegAddr = 5'd0;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

  typedef enum logic [3:0] {
    MOP_NONE, MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW, MOP_LL,
    MOP_SB, MOP_SH, MOP_SW, MOP_SC
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_WAIT_ACK, ST_DONE, ST_DRAIN
  } state_e;

  function automatic logic is_store(input mem_op_e op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW) || (op == MOP_SC);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data bus between the memory stage (master) and the
// memory slave; request side is registered by the master.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, sel, wdata, input ack, rdata);
  modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage_lane_align.sv
// Big-endian byte-lane alignment: byte enables, replicated store data,
// extended load result and misalignment flag. Purely combinational, no flow control.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_result,
  output logic        misalign
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane   = rdata[31:24];
    half_lane   = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    sel         = 4'b0000;
    wdata       = store_data;
    load_result = 32'h0000_0000;
    misalign    = 1'b0;

    case (addr_lo)
      2'd1:    byte_lane = rdata[23:16];
      2'd2:    byte_lane = rdata[15:8];
      2'd3:    byte_lane = rdata[7:0];
      default: byte_lane = rdata[31:24];
    endcase

    case (op)
      MOP_LB, MOP_LBU, MOP_SB: begin
        sel   = 4'b1000 >> addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      MOP_LH, MOP_LHU, MOP_SH: begin
        sel      = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata    = {2{store_data[15:0]}};
        misalign = addr_lo[0];
      end
      MOP_LW, MOP_LL, MOP_SW, MOP_SC: begin
        sel      = 4'b1111;
        misalign = |addr_lo;
      end
      default: ;
    endcase

    case (op)
      MOP_LB:         load_result = {{24{byte_lane[7]}}, byte_lane};
      MOP_LBU:        load_result = {24'h000000, byte_lane};
      MOP_LH:         load_result = {{16{half_lane[15]}}, half_lane};
      MOP_LHU:        load_result = {16'h0000, half_lane};
      MOP_LW, MOP_LL: load_result = rdata;
      default:        load_result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: loads/stores/LL/SC over a req/ack bus, result to MEM/WB.
// Latency: zero-wait access completes in 2 extra cycles, +1 per slave wait cycle.
// Backpressure: stallreq_mem while an access is pending; DONE holds until stall_ctrl[4] drops.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ALUOP_W = 8
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall_ctrl,
  input  logic                flush,
  input  logic [ALUOP_W-1:0]  ex_aluop,
  input  logic [RegWidth-1:0] ex_mem_addr,
  input  logic [RegWidth-1:0] ex_store_data,
  input  logic                ex_gpr_we,
  input  logic [4:0]          ex_target_gpr,
  input  logic [RegWidth-1:0] ex_exe_result,
  input  logic [RegWidth-1:0] ex_hi,
  input  logic [RegWidth-1:0] ex_lo,
  input  logic                ex_hilo_we,
  input  logic                ex_cp0_we,
  input  logic [4:0]          ex_cp0_waddr,
  input  logic [RegWidth-1:0] ex_cp0_wdata,
  input  logic                llbit_i,
  input  logic                wb_llbit_we,
  input  logic                wb_llbit_value,
  mem_access_stage_if.master  dbus,
  output logic                stallreq_mem,
  output logic                mem_gpr_we,
  output logic [4:0]          mem_target_gpr,
  output logic [RegWidth-1:0] mem_exe_result,
  output logic [RegWidth-1:0] mem_hi,
  output logic [RegWidth-1:0] mem_lo,
  output logic                mem_hilo_we,
  output logic                mem_cp0_we,
  output logic [4:0]          mem_cp0_waddr,
  output logic [RegWidth-1:0] mem_cp0_wdata,
  output logic                mem_llbit_we,
  output logic                mem_llbit_value,
  output logic                mem_excp_adel,
  output logic                mem_excp_ades,
  output logic [RegWidth-1:0] mem_bad_addr
);

  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] hold_result_q, hold_result_d;
  logic        hold_gpr_we_q, hold_gpr_we_d;
  logic        hold_llbit_we_q, hold_llbit_we_d;
  logic        hold_llbit_value_q, hold_llbit_value_d;

  mem_op_e     op;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata, al_load_result;
  logic        misalign, llbit_eff, is_mem, is_st, sc_fail, start;
  logic        unused_stall;

  assign unused_stall = ^{stall_ctrl[5], stall_ctrl[3:0]};

  always_comb begin
    case (ex_aluop)
      ALUOP_W'(EXE_LB_OP):  op = MOP_LB;
      ALUOP_W'(EXE_LBU_OP): op = MOP_LBU;
      ALUOP_W'(EXE_LH_OP):  op = MOP_LH;
      ALUOP_W'(EXE_LHU_OP): op = MOP_LHU;
      ALUOP_W'(EXE_LW_OP):  op = MOP_LW;
      ALUOP_W'(EXE_LL_OP):  op = MOP_LL;
      ALUOP_W'(EXE_SB_OP):  op = MOP_SB;
      ALUOP_W'(EXE_SH_OP):  op = MOP_SH;
      ALUOP_W'(EXE_SW_OP):  op = MOP_SW;
      ALUOP_W'(EXE_SC_OP):  op = MOP_SC;
      default:              op = MOP_NONE;
    endcase
  end

  mem_lane_align u_align (
    .op          (op),
    .addr_lo     (ex_mem_addr[1:0]),
    .store_data  (ex_store_data),
    .rdata       (dbus.rdata),
    .sel         (al_sel),
    .wdata       (al_wdata),
    .load_result (al_load_result),
    .misalign    (misalign)
  );

  // WB forwarding wins so an LL/SC pair in adjacent slots sees the fresh LLbit
  assign llbit_eff = wb_llbit_we ? wb_llbit_value : llbit_i;
  assign is_mem    = (op != MOP_NONE);
  assign is_st     = is_store(op);
  assign sc_fail   = (op == MOP_SC) && !llbit_eff;
  assign start     = is_mem && !misalign && !flush && !sc_fail;

  always_comb begin
    state_d            = state_q;
    req_d              = req_q;
    we_d               = we_q;
    addr_d             = addr_q;
    sel_d              = sel_q;
    wdata_d            = wdata_q;
    hold_result_d      = hold_result_q;
    hold_gpr_we_d      = hold_gpr_we_q;
    hold_llbit_we_d    = hold_llbit_we_q;
    hold_llbit_value_d = hold_llbit_value_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_WAIT_ACK;
        req_d   = 1'b1;
        we_d    = is_st;
        addr_d  = {ex_mem_addr[31:2], 2'b00};
        sel_d   = al_sel;
        wdata_d = al_wdata;
      end
      ST_WAIT_ACK: begin
        if (dbus.ack) begin
          req_d = 1'b0;
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            state_d            = ST_DONE;
            hold_result_d      = (op == MOP_SC) ? 32'd1 : al_load_result;
            hold_gpr_we_d      = (op == MOP_SC) || (!is_st && ex_gpr_we);
            hold_llbit_we_d    = (op == MOP_LL) || (op == MOP_SC);
            hold_llbit_value_d = (op == MOP_LL);
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: if (!stall_ctrl[4] || flush) state_d = ST_IDLE;
      default: if (dbus.ack) begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q            <= ST_IDLE;
      req_q              <= 1'b0;
      we_q               <= 1'b0;
      addr_q             <= '0;
      sel_q              <= '0;
      wdata_q            <= '0;
      hold_result_q      <= '0;
      hold_gpr_we_q      <= 1'b0;
      hold_llbit_we_q    <= 1'b0;
      hold_llbit_value_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      req_q              <= req_d;
      we_q               <= we_d;
      addr_q             <= addr_d;
      sel_q              <= sel_d;
      wdata_q            <= wdata_d;
      hold_result_q      <= hold_result_d;
      hold_gpr_we_q      <= hold_gpr_we_d;
      hold_llbit_we_q    <= hold_llbit_we_d;
      hold_llbit_value_q <= hold_llbit_value_d;
    end
  end

  assign dbus.req   = req_q;
  assign dbus.we    = we_q;
  assign dbus.addr  = addr_q;
  assign dbus.sel   = sel_q;
  assign dbus.wdata = wdata_q;

  always_comb begin
    stallreq_mem    = 1'b0;
    mem_gpr_we      = ex_gpr_we;
    mem_target_gpr  = ex_target_gpr;
    mem_exe_result  = ex_exe_result;
    mem_hi          = ex_hi;
    mem_lo          = ex_lo;
    mem_hilo_we     = ex_hilo_we;
    mem_cp0_we      = ex_cp0_we;
    mem_cp0_waddr   = ex_cp0_waddr;
    mem_cp0_wdata   = ex_cp0_wdata;
    mem_llbit_we    = 1'b0;
    mem_llbit_value = 1'b0;
    mem_excp_adel   = 1'b0;
    mem_excp_ades   = 1'b0;
    mem_bad_addr    = '0;
    case (state_q)
      ST_IDLE: if (is_mem) begin
        mem_gpr_we = 1'b0;
        if (misalign) begin
          mem_excp_adel = !is_st;
          mem_excp_ades = is_st;
          mem_bad_addr  = ex_mem_addr;
        end else if (sc_fail) begin
          mem_exe_result = '0;
          mem_gpr_we     = 1'b1;
        end else begin
          stallreq_mem = !flush;
        end
      end
      ST_WAIT_ACK: begin
        stallreq_mem = 1'b1;
        mem_gpr_we   = 1'b0;
      end
      ST_DONE: begin
        mem_exe_result  = hold_result_q;
        mem_gpr_we      = hold_gpr_we_q;
        mem_llbit_we    = hold_llbit_we_q;
        mem_llbit_value = hold_llbit_value_q;
      end
      default: if (is_mem) begin
        stallreq_mem = 1'b1;
        mem_gpr_we   = 1'b0;
      end
    endcase
    if (flush) begin
      mem_gpr_we    = 1'b0;
      mem_hilo_we   = 1'b0;
      mem_cp0_we    = 1'b0;
      mem_llbit_we  = 1'b0;
      mem_excp_adel = 1'b0;
      mem_excp_ades = 1'b0;
    end
    if (rst == RstEnable) begin
      stallreq_mem    = 1'b0;
      mem_gpr_we      = 1'b0;
      mem_target_gpr  = NOPRegAddr;
      mem_exe_result  = '0;
      mem_hi          = '0;
      mem_lo          = '0;
      mem_hilo_we     = 1'b0;
      mem_cp0_we      = 1'b0;
      mem_cp0_waddr   = '0;
      mem_cp0_wdata   = '0;
      mem_llbit_we    = 1'b0;
      mem_llbit_value = 1'b0;
      mem_excp_adel   = 1'b0;
      mem_excp_ades   = 1'b0;
      mem_bad_addr    = '0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, ex_gpr_we, ex_hilo_we, ex_cp0_we;
  logic [5:0]  stall_ctrl;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr, ex_store_data, ex_exe_result, ex_hi, ex_lo, ex_cp0_wdata;
  logic [4:0]  ex_target_gpr, ex_cp0_waddr;
  logic        llbit_i, wb_llbit_we, wb_llbit_value;
  logic        stallreq_mem, mem_gpr_we, mem_hilo_we, mem_cp0_we;
  logic [4:0]  mem_target_gpr, mem_cp0_waddr;
  logic [31:0] mem_exe_result, mem_hi, mem_lo, mem_cp0_wdata, mem_bad_addr;
  logic        mem_llbit_we, mem_llbit_value, mem_excp_adel, mem_excp_ades;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if dbus ();

  mem_access_stage #(.ALUOP_W(8)) dut (
    .clk(clk), .rst(rst), .stall_ctrl(stall_ctrl), .flush(flush),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .ex_gpr_we(ex_gpr_we), .ex_target_gpr(ex_target_gpr), .ex_exe_result(ex_exe_result),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo_we(ex_hilo_we),
    .ex_cp0_we(ex_cp0_we), .ex_cp0_waddr(ex_cp0_waddr), .ex_cp0_wdata(ex_cp0_wdata),
    .llbit_i(llbit_i), .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value),
    .dbus(dbus), .stallreq_mem(stallreq_mem),
    .mem_gpr_we(mem_gpr_we), .mem_target_gpr(mem_target_gpr), .mem_exe_result(mem_exe_result),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_hilo_we(mem_hilo_we),
    .mem_cp0_we(mem_cp0_we), .mem_cp0_waddr(mem_cp0_waddr), .mem_cp0_wdata(mem_cp0_wdata),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .mem_excp_adel(mem_excp_adel), .mem_excp_ades(mem_excp_ades), .mem_bad_addr(mem_bad_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic gwe);
    ex_aluop      = op;
    ex_mem_addr   = addr;
    ex_store_data = sd;
    ex_gpr_we     = gwe;
    ex_target_gpr = 5'd9;
    ex_exe_result = addr;
  endtask

  task automatic nop();
    ex_aluop      = 8'h00;
    ex_mem_addr   = 32'h0;
    ex_store_data = 32'h0;
    ex_gpr_we     = 1'b0;
    ex_target_gpr = 5'd0;
    ex_exe_result = 32'h77;
  endtask

  // Zero-wait load: request in cycle 1, result in DONE (cycle 2), advance at end of cycle 2.
  task automatic do_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [3:0] exp_sel,
                         input logic [31:0] exp_res, input logic exp_llwe, input logic exp_llval);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    set_op(op, addr, 32'h0, 1'b1);
    #2;
    chk({tag, "_c0_stall"}, {31'b0, stallreq_mem}, 32'd1);
    chk({tag, "_c0_req"}, {31'b0, dbus.req}, 32'd0);
    tick();
    chk({tag, "_c1_req"}, {31'b0, dbus.req}, 32'd1);
    chk({tag, "_c1_sel"}, {28'b0, dbus.sel}, {28'b0, exp_sel});
    chk({tag, "_c1_addr"}, dbus.addr, waddr);
    chk({tag, "_c1_we"}, {31'b0, dbus.we}, 32'd0);
    dbus.ack   = 1'b1;
    dbus.rdata = rdata;
    #2;
    chk({tag, "_c1_stall"}, {31'b0, stallreq_mem}, 32'd1);
    tick();
    dbus.ack   = 1'b0;
    dbus.rdata = 32'h0;
    #1;
    chk({tag, "_c2_result"}, mem_exe_result, exp_res);
    chk({tag, "_c2_stall"}, {31'b0, stallreq_mem}, 32'd0);
    chk({tag, "_c2_req"}, {31'b0, dbus.req}, 32'd0);
    chk({tag, "_c2_gpr_we"}, {31'b0, mem_gpr_we}, 32'd1);
    chk({tag, "_c2_llbit_we"}, {31'b0, mem_llbit_we}, {31'b0, exp_llwe});
    chk({tag, "_c2_llbit_val"}, {31'b0, mem_llbit_value}, {31'b0, exp_llval});
    tick();
    nop();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall_ctrl = 6'b0;
    ex_hi = 32'h0; ex_lo = 32'h0; ex_hilo_we = 1'b0;
    ex_cp0_we = 1'b0; ex_cp0_waddr = 5'd0; ex_cp0_wdata = 32'h0;
    llbit_i = 1'b0; wb_llbit_we = 1'b0; wb_llbit_value = 1'b0;
    dbus.ack = 1'b0; dbus.rdata = 32'h0;
    nop();
    tick();
    chk("rst_req", {31'b0, dbus.req}, 32'd0);
    chk("rst_addr", dbus.addr, 32'h0);
    chk("rst_sel", {28'b0, dbus.sel}, 32'h0);
    chk("rst_stall", {31'b0, stallreq_mem}, 32'd0);
    chk("rst_result", mem_exe_result, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Non-memory op passes straight through
    ex_aluop = 8'h21; ex_exe_result = 32'h1234_5678; ex_gpr_we = 1'b1; ex_target_gpr = 5'd3;
    ex_hi = 32'hAAAA_0000; ex_lo = 32'h0000_BBBB; ex_hilo_we = 1'b1;
    ex_cp0_we = 1'b1; ex_cp0_waddr = 5'd12; ex_cp0_wdata = 32'h5;
    #2;
    chk("pass_result", mem_exe_result, 32'h1234_5678);
    chk("pass_gpr_we", {31'b0, mem_gpr_we}, 32'd1);
    chk("pass_target", {27'b0, mem_target_gpr}, 32'd3);
    chk("pass_hi", mem_hi, 32'hAAAA_0000);
    chk("pass_lo", mem_lo, 32'h0000_BBBB);
    chk("pass_hilo_we", {31'b0, mem_hilo_we}, 32'd1);
    chk("pass_cp0_waddr", {27'b0, mem_cp0_waddr}, 32'd12);
    chk("pass_stall", {31'b0, stallreq_mem}, 32'd0);
    flush = 1'b1;
    #2;
    chk("flush_gpr_we", {31'b0, mem_gpr_we}, 32'd0);
    chk("flush_hilo_we", {31'b0, mem_hilo_we}, 32'd0);
    chk("flush_cp0_we", {31'b0, mem_cp0_we}, 32'd0);
    tick();
    chk("pass_no_req", {31'b0, dbus.req}, 32'd0);
    flush = 1'b0; ex_hilo_we = 1'b0; ex_cp0_we = 1'b0;
    nop();
    tick();

    do_load("lw", EXE_LW_OP, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_load("lb", EXE_LB_OP, 32'h0000_2003, 32'h1122_3380, 4'b0001, 32'hFFFF_FF80, 1'b0, 1'b0);
    do_load("lbu", EXE_LBU_OP, 32'h0000_2003, 32'h1122_3380, 4'b0001, 32'h0000_0080, 1'b0, 1'b0);
    do_load("lh", EXE_LH_OP, 32'h0000_2000, 32'h8123_4567, 4'b1100, 32'hFFFF_8123, 1'b0, 1'b0);
    do_load("lhu", EXE_LHU_OP, 32'h0000_2002, 32'h1234_9ABC, 4'b0011, 32'h0000_9ABC, 1'b0, 1'b0);

    // SH with three slave wait cycles: request attributes steady for 4 cycles
    set_op(EXE_SH_OP, 32'h0000_1002, 32'h0000_BEEF, 1'b0);
    #2;
    chk("sh_c0_stall", {31'b0, stallreq_mem}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) dbus.ack = 1'b1;
      chk("sh_req", {31'b0, dbus.req}, 32'd1);
      chk("sh_sel", {28'b0, dbus.sel}, 32'h3);
      chk("sh_wdata", dbus.wdata, 32'hBEEF_BEEF);
      chk("sh_we", {31'b0, dbus.we}, 32'd1);
      chk("sh_addr", dbus.addr, 32'h0000_1000);
      chk("sh_stall", {31'b0, stallreq_mem}, 32'd1);
    end
    tick();
    dbus.ack = 1'b0;
    #1;
    chk("sh_done_req", {31'b0, dbus.req}, 32'd0);
    chk("sh_done_gpr_we", {31'b0, mem_gpr_we}, 32'd0);
    chk("sh_done_stall", {31'b0, stallreq_mem}, 32'd0);
    tick();
    nop();
    tick();

    do_load("ll", EXE_LL_OP, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1'b1, 1'b1);

    // SC succeeding through the forwarded WB LLbit
    llbit_i = 1'b0; wb_llbit_we = 1'b1; wb_llbit_value = 1'b1;
    set_op(EXE_SC_OP, 32'h0000_0040, 32'h55AA_55AA, 1'b1);
    #2;
    chk("sc_c0_stall", {31'b0, stallreq_mem}, 32'd1);
    tick();
    chk("sc_req", {31'b0, dbus.req}, 32'd1);
    chk("sc_we", {31'b0, dbus.we}, 32'd1);
    chk("sc_wdata", dbus.wdata, 32'h55AA_55AA);
    chk("sc_sel", {28'b0, dbus.sel}, 32'hF);
    dbus.ack = 1'b1;
    tick();
    dbus.ack = 1'b0;
    #1;
    chk("sc_result", mem_exe_result, 32'd1);
    chk("sc_gpr_we", {31'b0, mem_gpr_we}, 32'd1);
    chk("sc_llbit_we", {31'b0, mem_llbit_we}, 32'd1);
    chk("sc_llbit_val", {31'b0, mem_llbit_value}, 32'd0);
    tick();
    nop();
    wb_llbit_we = 1'b0; wb_llbit_value = 1'b0;
    tick();

    // SC failing: no bus access, result 0 written back immediately
    llbit_i = 1'b0;
    set_op(EXE_SC_OP, 32'h0000_0040, 32'h55AA_55AA, 1'b1);
    #2;
    chk("scf_stall", {31'b0, stallreq_mem}, 32'd0);
    chk("scf_result", mem_exe_result, 32'd0);
    chk("scf_gpr_we", {31'b0, mem_gpr_we}, 32'd1);
    tick();
    chk("scf_req", {31'b0, dbus.req}, 32'd0);
    nop();
    tick();

    // Address errors
    set_op(EXE_LW_OP, 32'h0000_1001, 32'h0, 1'b1);
    #2;
    chk("adel_flag", {31'b0, mem_excp_adel}, 32'd1);
    chk("adel_ades", {31'b0, mem_excp_ades}, 32'd0);
    chk("adel_bad_addr", mem_bad_addr, 32'h0000_1001);
    chk("adel_gpr_we", {31'b0, mem_gpr_we}, 32'd0);
    chk("adel_stall", {31'b0, stallreq_mem}, 32'd0);
    tick();
    chk("adel_req", {31'b0, dbus.req}, 32'd0);
    set_op(EXE_SW_OP, 32'h0000_1002, 32'h0, 1'b0);
    #2;
    chk("ades_flag", {31'b0, mem_excp_ades}, 32'd1);
    chk("ades_adel", {31'b0, mem_excp_adel}, 32'd0);
    chk("ades_bad_addr", mem_bad_addr, 32'h0000_1002);
    tick();
    chk("ades_req", {31'b0, dbus.req}, 32'd0);
    nop();
    tick();

    // Flush while waiting for ack: request drains, data discarded
    set_op(EXE_LW_OP, 32'h0000_3000, 32'h0, 1'b1);
    tick();
    chk("fl_req_c1", {31'b0, dbus.req}, 32'd1);
    flush = 1'b1;
    #2;
    chk("fl_gpr_we", {31'b0, mem_gpr_we}, 32'd0);
    chk("fl_llbit_we", {31'b0, mem_llbit_we}, 32'd0);
    chk("fl_adel", {31'b0, mem_excp_adel}, 32'd0);
    tick();
    flush = 1'b0;
    nop();
    #2;
    chk("fl_drain_req", {31'b0, dbus.req}, 32'd1);
    chk("fl_drain_stall", {31'b0, stallreq_mem}, 32'd0);
    dbus.ack = 1'b1;
    dbus.rdata = 32'h9999_9999;
    tick();
    dbus.ack = 1'b0;
    #1;
    chk("fl_req_dropped", {31'b0, dbus.req}, 32'd0);
    chk("fl_discard", mem_exe_result, 32'h77);
    do_load("after_fl", EXE_LW_OP, 32'h0000_3004, 32'h0102_0304, 4'b1111, 32'h0102_0304, 1'b0, 1'b0);

    // DONE held by the pipeline for 3 cycles, leaves on release
    set_op(EXE_LW_OP, 32'h0000_0050, 32'h0, 1'b1);
    tick();
    dbus.ack = 1'b1;
    dbus.rdata = 32'h0BAD_F00D;
    tick();
    dbus.ack = 1'b0;
    dbus.rdata = 32'h0;
    stall_ctrl = 6'b01_0000;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) tick();
      chk("hold_result", mem_exe_result, 32'h0BAD_F00D);
      chk("hold_gpr_we", {31'b0, mem_gpr_we}, 32'd1);
      chk("hold_stall", {31'b0, stallreq_mem}, 32'd0);
      chk("hold_req", {31'b0, dbus.req}, 32'd0);
    end
    stall_ctrl = 6'b0;
    tick();
    nop();
    #2;
    chk("hold_released", mem_exe_result, 32'h77);
    tick();

    // Reset mid-transaction drops the request at once
    set_op(EXE_LW_OP, 32'h0000_6000, 32'h0, 1'b1);
    tick();
    chk("rstmid_req_before", {31'b0, dbus.req}, 32'd1);
    rst = 1'b1;
    #2;
    chk("rstmid_req", {31'b0, dbus.req}, 32'd0);
    chk("rstmid_stall", {31'b0, stallreq_mem}, 32'd0);
    nop();
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid_idle_req", {31'b0, dbus.req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage between the EX/MEM and MEM/WB pipeline registers. It runs loads, stores and LL/SC over a request/acknowledge data bus, and handles big-endian byte-lane alignment. It raises a pipeline stall request while a bus access is outstanding. It presents the combined stage result, LLbit updates and pass-through HI/LO/CP0 writes on `mem_*` outputs, and the MEM/WB register captures those outputs.

## Interface
- `ALUOP_W`, default 8, width of the `ex_aluop` code.
- `clk`  in  1  stage clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall_ctrl`  in  6  pipeline stall vector; bit 4 = MEM stage held.
- `flush`  in  1  exception flush; kills the instruction in MEM.
- `ex_aluop`  in  `ALUOP_W`  operation: LB, LBU, LH, LHU, LW, LL, SB, SH, SW, SC, or other (non-memory).
- `ex_mem_addr`  in  32  effective address.
- `ex_store_data`  in  32  store source register value.
- `ex_gpr_we`, `ex_target_gpr[4:0]`, `ex_exe_result[31:0]`  in  GPR write request from EX.
- `ex_hi[31:0]`, `ex_lo[31:0]`, `ex_hilo_we`  in  HI/LO write request from EX; passed through unchanged.
- `ex_cp0_we`, `ex_cp0_waddr[4:0]`, `ex_cp0_wdata[31:0]`  in  CP0 write request from EX; passed through unchanged.
- `llbit_i`  in  1  architectural LLbit.
- `wb_llbit_we`, `wb_llbit_value`  in  1 each  LLbit write in flight in WB, used for forwarding.
- `dbus_ack`  in  1  slave completion strobe.
- `dbus_rdata`  in  32  read data; valid when `dbus_ack` = 1.
- `dbus_req`, `dbus_we`  out  1 each  registered request and write strobe.
- `dbus_addr`  out  32  registered word address; bits [1:0] are forced to 0.
- `dbus_sel`  out  4  byte enables; bit 3 = bits [31:24].
- `dbus_wdata`  out  32  replicated store data.
- `stallreq_mem`  out  1  stall request to the pipeline controller.
- `mem_gpr_we`, `mem_target_gpr`, `mem_exe_result`, `mem_hi`, `mem_lo`, `mem_hilo_we`, `mem_cp0_we`, `mem_cp0_waddr`, `mem_cp0_wdata`  out  stage result to MEM/WB; each has the width of its `ex_*` counterpart.
- `mem_llbit_we`, `mem_llbit_value`  out  1 each  LLbit update.
- `mem_excp_adel`, `mem_excp_ades`  out  1 each  load / store address error.
- `mem_bad_addr`  out  32  faulting address.

## Operation
- Non-memory op: `ex_*` → `mem_*` combinationally; `stallreq_mem` = 0; no bus activity.
- Effective LLbit = `wb_llbit_value` if `wb_llbit_we`, else `llbit_i`.
- Alignment errors (no bus access; `mem_gpr_we` = 0; `mem_bad_addr` = address):
  - LH/LHU/SH with addr[0] = 1.
  - LW/LL/SW/SC with addr[1:0] ≠ 0.
  - Loads raise `mem_excp_adel`; stores raise `mem_excp_ades`.
- Byte lanes are big-endian.
  - Byte: addr 00 → sel 1000 … addr 11 → sel 0001.
  - Half: addr 00 → sel 1100; addr 10 → sel 0011.
  - Word: sel 1111.
  - Store data is replicated across lanes: byte ×4, half ×2.
- Load result:
  - Selected lane, sign-extended for LB/LH, zero-extended for LBU/LHU.
  - LL: full word, plus `mem_llbit_we` = 1 and `mem_llbit_value` = 1.
- SC:
  - Effective LLbit = 0: no bus access; `mem_exe_result` = 0; `mem_gpr_we` = 1.
  - Effective LLbit = 1: word store; `mem_exe_result` = 1; `mem_llbit_we` = 1 and `mem_llbit_value` = 0 on completion.
- FSM states are IDLE, WAIT_ACK, DONE and DRAIN.
  - IDLE: a valid access (memory op, aligned, no `flush`, SC success) sets `stallreq_mem` = 1 combinationally. The next edge registers the `dbus_*` outputs, asserts `dbus_req` and moves to WAIT_ACK.
  - WAIT_ACK: `dbus_req` is held and `stallreq_mem` = 1. When `dbus_ack` = 1, the edge captures the aligned result into a holding register, drops `dbus_req` and moves to DONE.
  - DONE: `stallreq_mem` = 0 and `mem_*` are driven from the holding register. The state moves to IDLE on the first edge with `stall_ctrl[4]` = 0 or `flush` = 1; otherwise it holds.
  - DRAIN: entered on `flush` during WAIT_ACK. `dbus_req` stays asserted until `dbus_ack`, then the state moves to IDLE and the read data is discarded. A new access does not start from DRAIN; if a memory op is present, `stallreq_mem` = 1.
- Whenever `flush` = 1 the killed instruction produces no write: all `*_we` outputs are 0 and both exception flags are 0.

## Timing
- Reset value is 0 for every output, the holding register and every `dbus_*` output. The state resets to IDLE.
- Reset asserted mid-transaction abandons the bus request immediately.
- Zero-wait slave (ack in the first request cycle):
  - Op enters MEM in cycle 0; `dbus_req` is high in cycle 1.
  - DONE in cycle 2; the stage advances at the end of cycle 2.
  - Each added wait cycle adds one cycle.
- `dbus_req` stays continuously high from assertion to the ack edge.
- `dbus_addr`, `dbus_sel`, `dbus_we` and `dbus_wdata` stay constant while `dbus_req` = 1.
- SC failure and alignment errors complete in 0 extra cycles.

## Structure
- Shared defines header holds the ALU-op codes for the memory ops, `RstEnable`, `NOPRegAddr` and `RegWidth`.
- One combinational sub-module, `mem_lane_align`:
  - Inputs: op, addr[1:0], store data, read data.
  - Outputs: sel, wdata, load result, misalignment flag.
- The FSM, holding register and output muxing stay in the top module.

## Test plan
- LW at 0x1000, ack in the first request cycle, rdata 0xDEADBEEF → `dbus_sel` = 1111; `mem_exe_result` = 0xDEADBEEF in cycle 2; `stallreq_mem` high in cycles 0–1 only.
- LB at 0x2003, rdata 0x11223380 → `mem_exe_result` = 0xFFFFFF80; LBU at the same address → 0x00000080.
- SH at 0x1002, store data 0x0000BEEF, 3 wait cycles → `dbus_sel` = 0011 and `dbus_wdata` = 0xBEEFBEEF held steady for 4 cycles; `mem_gpr_we` = 0.
- LL at 0x40 then SC at 0x40 with `wb_llbit_we`/`wb_llbit_value` = 1/1 → SC stores and returns 1, `mem_llbit_value` = 0. Repeat with `llbit_i` = 0 and no WB write → no `dbus_req`, result 0.
- LW at 0x1001 → `mem_excp_adel` = 1, `mem_bad_addr` = 0x1001, no `dbus_req`, `mem_gpr_we` = 0.
- `flush` in WAIT_ACK → `dbus_req` held until ack, no write outputs, return to IDLE. Separately, DONE with `stall_ctrl[4]` = 1 for 3 cycles → outputs held stable, leave DONE on release.
